stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
// Sequencing controller for the stopwatch. Consumes single-cycle tick enables from
// clock_dividers (1 Hz count, 2 Hz adjust/blink) and debounced user controls.
// Owns the RUN/PAUSE/ADJUST state machine and the minutes/seconds counters.
// Drives the display formatter with binary time and per-field blink gates.
// PARAMETERS
// MAX_MIN   59   minutes value that wraps to 0 (legal range 1..99)
// MAX_SEC   59   seconds value that wraps to 0
// PORTS
// clk_in    in   1  system clock; all state changes on rising edge
// rst       in   1  asynchronous reset, active-low
// tick_1hz  in   1  1-cycle count enable, synchronous to clk_in
// tick_2hz  in   1  1-cycle adjust/blink enable, synchronous to clk_in
// pause_p   in   1  1-cycle pulse (debounced); toggles pause
// clr_p     in   1  1-cycle pulse (debounced); clears time
// adj       in   1  level; 1 = adjust mode
// sel       in   1  level; in adjust: 0 = minutes, 1 = seconds
// minutes   out  7  current minutes, 0..MAX_MIN
// seconds   out  6  current seconds, 0..MAX_SEC
// blink_min out  1  1 = blank minutes digits this phase
// blink_sec out  1  1 = blank seconds digits this phase
// running   out  1  1 when state == RUN
// state     out  2  00 RUN, 01 PAUSE, 10 ADJ_MIN, 11 ADJ_SEC
// BEHAVIOUR
// - rst low (async): minutes=0, seconds=0, state=PAUSE, paused flag=1,
//   blink phase=0, blink_min=0, blink_sec=0, running=0.
// - All outputs registered. Any input event changes outputs 1 cycle later.
// - Every decision uses the current (pre-edge) state.
// - Transitions:
//   - adj=1 from any state -> ADJ_SEC if sel else ADJ_MIN.
//   - In ADJ_MIN/ADJ_SEC, sel change -> the other ADJ state.
//   - adj=0 while in ADJ -> PAUSE if paused flag, else RUN.
//   - RUN/PAUSE: pause_p toggles paused flag and swaps RUN<->PAUSE.
//   - ADJ states: pause_p toggles the flag only; the state is unchanged.
// - RUN, tick_1hz:
//   - seconds+1.
//   - seconds==MAX_SEC -> seconds=0, minutes+1.
//   - minutes==MAX_MIN with that carry -> minutes=0.
// - ADJ_MIN, tick_2hz: minutes+1, wrap MAX_MIN->0; seconds hold.
// - ADJ_SEC, tick_2hz: seconds+1, wrap MAX_SEC->0; no carry into minutes.
// - PAUSE: counters hold.
// - tick_1hz is ignored in ADJ states. tick_2hz is ignored in RUN/PAUSE.
// - Blink phase:
//   - Toggles on each tick_2hz while in an ADJ state.
//   - Forced to 0 on entry to either ADJ state, including an ADJ_MIN<->ADJ_SEC swap.
//   - blink_min = phase & ADJ_MIN; blink_sec = phase & ADJ_SEC.
// - clr_p:
//   - Sets minutes=0, seconds=0 next cycle; state and paused flag unchanged.
//   - Wins over a same-cycle tick; the result is 00:00, not 00:01.
// - Simultaneous events:
//   - pause_p with tick_1hz in RUN: tick counts; PAUSE from next cycle.
//   - adj rise with tick_1hz in RUN: tick counts; ADJ from next cycle.
// - Counters never take values above MAX_MIN/MAX_SEC.
// TESTING
// - rst low mid-run at 03:12, async between edges -> outputs 0 before next edge,
//   state=01.
// - Release rst, pause_p, then 61 tick_1hz -> minutes=1, seconds=1, running=1.
// - Preset 59:59 via adjust, return to RUN, one tick_1hz -> 00:00.
// - adj=1 sel=0 at 10:20, 5 tick_2hz plus 3 tick_1hz -> 15:20;
//   blink_min toggles per tick_2hz; blink_sec=0.
// - In ADJ, sel->1 -> state=11 and phase=0 next cycle.
//   From sec=58, 3 tick_2hz -> sec=1, min unchanged.
// - Enter ADJ from RUN, pause_p, adj=0 -> state=PAUSE.
//   clr_p with tick_1hz in RUN -> 00:00.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: RUN/PAUSE/ADJUST state machine, minutes and
// seconds counters, and per-field blink gating for the display formatter.

module stopwatch_ctrl_chk #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input logic       clk_in,
  input logic       rst,
  input logic [6:0] minutes,
  input logic [5:0] seconds,
  input logic       blink_min,
  input logic       blink_sec,
  input logic       running,
  input logic [1:0] state
);
  localparam logic [6:0] MIN_TOP = 7'(MAX_MIN);
  localparam logic [5:0] SEC_TOP = 6'(MAX_SEC);

  // Output invariants that must hold in every cycle out of reset.
  a_min_range : assert property (@(posedge clk_in) disable iff (!rst) minutes <= MIN_TOP);
  a_sec_range : assert property (@(posedge clk_in) disable iff (!rst) seconds <= SEC_TOP);
  a_blink_one : assert property (@(posedge clk_in) disable iff (!rst) !(blink_min && blink_sec));
  a_run_state : assert property (@(posedge clk_in) disable iff (!rst) running == (state == 2'b00));
  a_bmin_st   : assert property (@(posedge clk_in) disable iff (!rst) blink_min |-> (state == 2'b10));
  a_bsec_st   : assert property (@(posedge clk_in) disable iff (!rst) blink_sec |-> (state == 2'b11));
endmodule

module stopwatch_ctrl #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_p,
  input  logic       clr_p,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       blink_min,
  output logic       blink_sec,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PAUSE   = 2'b01,
    ST_ADJ_MIN = 2'b10,
    ST_ADJ_SEC = 2'b11
  } state_e;

  localparam logic [6:0] MIN_TOP = 7'(MAX_MIN);
  localparam logic [5:0] SEC_TOP = 6'(MAX_SEC);

  state_e     state_q, state_d;
  logic       paused_q, paused_d;
  logic       phase_q, phase_d;
  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       blink_min_q, blink_min_d;
  logic       blink_sec_q, blink_sec_d;
  logic       running_q, running_d;

  // Out-of-range values also fold to zero so a corrupted counter self-heals.
  function automatic logic [6:0] inc_min(input logic [6:0] v);
    logic [6:0] r;
    if (v >= MIN_TOP) begin
      r = 7'd0;
    end else begin
      r = v + 7'd1;
    end
    return r;
  endfunction

  function automatic logic [5:0] inc_sec(input logic [5:0] v);
    logic [5:0] r;
    if (v >= SEC_TOP) begin
      r = 6'd0;
    end else begin
      r = v + 6'd1;
    end
    return r;
  endfunction

  function automatic logic is_adj(input state_e s);
    return s[1];
  endfunction

  // Next state and the paused flag that remembers where ADJ returns to.
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    if (pause_p) begin
      paused_d = ~paused_q;
    end else begin
      paused_d = paused_q;
    end
    if (adj) begin
      state_d = sel ? ST_ADJ_SEC : ST_ADJ_MIN;
    end else begin
      case (state_q)
        ST_RUN:     state_d = pause_p ? ST_PAUSE : ST_RUN;
        ST_PAUSE:   state_d = pause_p ? ST_RUN : ST_PAUSE;
        ST_ADJ_MIN,
        ST_ADJ_SEC: state_d = paused_q ? ST_PAUSE : ST_RUN;
        default:    state_d = ST_PAUSE;
      endcase
    end
  end

  // Counter update; clear overrides any tick arriving in the same cycle.
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (clr_p) begin
      min_d = 7'd0;
      sec_d = 6'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_1hz) begin
            if (sec_q >= SEC_TOP) begin
              sec_d = 6'd0;
              min_d = inc_min(min_q);
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            sec_d = sec_q;
          end
        end
        ST_ADJ_MIN: begin
          if (tick_2hz) begin
            min_d = inc_min(min_q);
          end else begin
            min_d = min_q;
          end
        end
        ST_ADJ_SEC: begin
          if (tick_2hz) begin
            sec_d = inc_sec(sec_q);
          end else begin
            sec_d = sec_q;
          end
        end
        ST_PAUSE: begin
          min_d = min_q;
          sec_d = sec_q;
        end
        default: begin
          min_d = min_q;
          sec_d = sec_q;
        end
      endcase
    end
  end

  // Blink phase restarts dark-off whenever an adjust field is (re)selected.
  always_comb begin
    phase_d = 1'b0;
    if (!is_adj(state_d)) begin
      phase_d = 1'b0;
    end else if (state_d != state_q) begin
      phase_d = 1'b0;
    end else if (tick_2hz) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
    blink_min_d = phase_d & (state_d == ST_ADJ_MIN);
    blink_sec_d = phase_d & (state_d == ST_ADJ_SEC);
    running_d   = (state_d == ST_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_PAUSE;
      paused_q    <= 1'b1;
      phase_q     <= 1'b0;
      min_q       <= 7'd0;
      sec_q       <= 6'd0;
      blink_min_q <= 1'b0;
      blink_sec_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paused_q    <= paused_d;
      phase_q     <= phase_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      blink_min_q <= blink_min_d;
      blink_sec_q <= blink_sec_d;
      running_q   <= running_d;
    end
  end

  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign blink_min = blink_min_q;
  assign blink_sec = blink_sec_q;
  assign running   = running_q;
  assign state     = state_q;

  stopwatch_ctrl_chk #(
    .MAX_MIN(MAX_MIN),
    .MAX_SEC(MAX_SEC)
  ) u_chk (
    .clk_in   (clk_in),
    .rst      (rst),
    .minutes  (minutes),
    .seconds  (seconds),
    .blink_min(blink_min),
    .blink_sec(blink_sec),
    .running  (running),
    .state    (state)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a vector table for single-cycle behaviour
// plus hand-written sequences for wraps, adjust blinking and async reset.

module tb_stopwatch_ctrl;
  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       pause_p = 1'b0;
  logic       clr_p = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       blink_min;
  logic       blink_sec;
  logic       running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.MAX_MIN(59), .MAX_SEC(59)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .pause_p  (pause_p),
    .clr_p    (clr_p),
    .adj      (adj),
    .sel      (sel),
    .minutes  (minutes),
    .seconds  (seconds),
    .blink_min(blink_min),
    .blink_sec(blink_sec),
    .running  (running),
    .state    (state)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic p, c, a, s, t1, t2;
    int   mins, secs, st, bm, bs, run;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic p, c, a, s, t1, t2,
                              input int mins, secs, st, bm, bs, run);
    vec_t v;
    v.p = p; v.c = c; v.a = a; v.s = s; v.t1 = t1; v.t2 = t2;
    v.mins = mins; v.secs = secs; v.st = st; v.bm = bm; v.bs = bs; v.run = run;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int m, s, st, bm, bs, run);
    check({tag, ".min"}, 32'(minutes), m);
    check({tag, ".sec"}, 32'(seconds), s);
    check({tag, ".state"}, 32'(state), st);
    check({tag, ".blink_min"}, 32'(blink_min), bm);
    check({tag, ".blink_sec"}, 32'(blink_sec), bs);
    check({tag, ".running"}, 32'(running), run);
  endtask

  // One clock cycle: drive at negedge, return 1 time unit after the posedge.
  task automatic cyc(input logic p, c, a, s, t1, t2);
    @(negedge clk_in);
    pause_p = p; clr_p = c; adj = a; sel = s; tick_1hz = t1; tick_2hz = t2;
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n, input logic a, s, t1, t2);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a, s, t1, t2);
  endtask

  initial begin
    int  ph;
    //              p  c  a  s  t1 t2   min sec st bm bs run
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    vecs[1]  = mk(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 1, 1,  0, 2, 0, 0, 0, 1);
    vecs[3]  = mk(1, 0, 0, 0, 1, 0,  0, 3, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0,  0, 3, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 0, 0,  0, 3, 2, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 0, 1,  1, 3, 2, 1, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 1, 0,  1, 3, 2, 1, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 1,  2, 3, 2, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 0, 1,  3, 3, 2, 1, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 0, 0,  3, 3, 3, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 1, 0, 1,  3, 4, 3, 0, 1, 0);
    vecs[12] = mk(0, 1, 1, 1, 0, 1,  0, 0, 3, 0, 0, 0);
    vecs[13] = mk(1, 0, 1, 1, 0, 0,  0, 0, 3, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1);
    vecs[16] = mk(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 1, 1, 1, 0,  0, 1, 3, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 1);

    #12;
    check_out("reset", 0, 0, 1, 0, 0, 0);
    @(negedge clk_in);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].p, vecs[i].c, vecs[i].a, vecs[i].s, vecs[i].t1, vecs[i].t2);
      check_out($sformatf("vec%0d", i), vecs[i].mins, vecs[i].secs, vecs[i].st,
                vecs[i].bm, vecs[i].bs, vecs[i].run);
    end

    // Reset again, start, 61 seconds of counting.
    @(negedge clk_in);
    rst = 1'b0;
    #1;
    check_out("rst2", 0, 0, 1, 0, 0, 0);
    @(negedge clk_in);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(61, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("count61", 1, 1, 0, 0, 0, 1);

    // Preset 59:59 through adjust, including the minutes wrap in ADJ_MIN.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(58, 1'b1, 1'b0, 1'b0, 1'b1);
    check("adjmin59", 32'(minutes), 59);
    ticks(1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("adjmin_wrap", 32'(minutes), 0);
    ticks(59, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    ticks(58, 1'b1, 1'b1, 1'b0, 1'b1);
    check_out("preset", 59, 59, 3, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("back_run", 59, 59, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("hour_wrap", 0, 0, 0, 0, 0, 1);

    // Preset 10:20, then adjust minutes with interleaved 1 Hz ticks.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    ticks(20, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("at1020", 10, 20, 2, 0, 0, 0);
    ph = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1 || k == 3 || k == 5) begin
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      end else begin
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        ph = 1 - ph;
      end
      check($sformatf("blink_min_k%0d", k), 32'(blink_min), ph);
      check($sformatf("blink_sec_k%0d", k), 32'(blink_sec), 0);
    end
    check_out("at1520", 15, 20, 2, 1, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_out("swap_sec", 15, 20, 3, 0, 0, 0);
    ticks(38, 1'b1, 1'b1, 1'b0, 1'b1);
    check("sec58", 32'(seconds), 58);
    ticks(3, 1'b1, 1'b1, 1'b0, 1'b1);
    check_out("sec_wrap", 15, 1, 3, 0, 1, 0);

    // Pause toggled while adjusting decides where adjust exits to.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("exit_run", 15, 1, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("adj_pause", 15, 1, 2, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("exit_pause", 15, 1, 1, 0, 0, 0);

    // Run to 03:12 and hit async reset between clock edges.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("clr_pause", 0, 0, 1, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(192, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("at0312", 3, 12, 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 1, 0, 0, 0);
    @(negedge clk_in);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
